// File: rtl/axis_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the DCMAC adapter's AXIS TX input.
// Grants whole packets, gates new grants on mac_af, truncates over-long packets.
module axis_tx_pkt_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = 128,
    parameter int MAX_BEATS  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC-1:0]            s_tuser,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [KEEP_WIDTH-1:0]         m_tkeep,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic                          m_tuser,
    input  logic                          m_tready,
    input  logic                          mac_af,
    output logic [2:0]                    m_tid,
    output logic                          busy,
    output logic [31:0]                   pkt_cnt,
    output logic [15:0]                   trunc_cnt
);
    localparam int unsigned NS = NUM_SRC;
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [2:0]            grant, last_grant, pick_src, cand;
    logic                  pick_found;
    logic [BW-1:0]         beat_cnt;
    logic [7:0]            req, lst, usr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [KEEP_WIDTH-1:0] cur_keep;
    logic                  cur_valid, cur_last, cur_user;
    logic                  at_max, hs, drop_hs, trunc;

    // Per-source flags widened to 8 bits so the 3-bit grant indexes them directly.
    assign req       = 8'(s_tvalid);
    assign lst       = 8'(s_tlast);
    assign usr       = 8'(s_tuser);
    assign cur_valid = req[grant];
    assign cur_last  = lst[grant];
    assign cur_user  = usr[grant];

    assign at_max  = (beat_cnt == BW'(MAX_BEATS - 1));
    assign hs      = (state == PASS) && cur_valid && m_tready;
    assign drop_hs = (state == DROP) && cur_valid;
    assign trunc   = hs && at_max && !cur_last;

    always_comb begin
        cur_data = '0;
        cur_keep = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (grant == 3'(i)) begin
                cur_data = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                cur_keep = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_src   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NS; k++) begin
            cand = 3'((32'(last_grant) + k) % NS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_src   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!mac_af && pick_found) state_nxt = PASS;
            PASS: begin
                if (hs && cur_last)  state_nxt = IDLE;
                else if (trunc)      state_nxt = DROP;
            end
            DROP: if (drop_hs && cur_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_tdata  = cur_data;
        m_tkeep  = cur_keep;
        m_tvalid = (state == PASS) && cur_valid;
        m_tlast  = cur_last || ((state == PASS) && at_max);
        m_tuser  = cur_user || ((state == PASS) && at_max && !cur_last);
        s_tready = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            s_tready[i] = (grant == 3'(i)) &&
                          (((state == PASS) && m_tready) || (state == DROP));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= 3'(NUM_SRC - 1);
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            trunc_cnt  <= '0;
        end else begin
            if (state == IDLE && !mac_af && pick_found) begin
                grant    <= pick_src;
                beat_cnt <= '0;
            end
            if (hs && !at_max) beat_cnt <= beat_cnt + BW'(1);
            if (hs && (cur_last || at_max)) begin
                pkt_cnt    <= pkt_cnt + 32'd1;
                last_grant <= grant;
            end
            if (trunc) trunc_cnt <= trunc_cnt + 16'd1;
        end
    end

    assign m_tid = grant;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// Self-checking bench for axis_tx_pkt_arbiter: per-source packet models, a scoreboard
// of expected downstream beats (data, tlast, tuser, tid, cycle gap) and scenario tasks.
module tb_axis_tx_pkt_arbiter;
    localparam int NS = 4;
    localparam int DW = 1024;
    localparam int KW = 128;
    localparam int MB = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*KW-1:0] s_tkeep;
    logic [NS-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid, m_tlast, m_tuser, m_tready, mac_af, busy;
    logic [2:0]       m_tid;
    logic [31:0]      pkt_cnt;
    logic [15:0]      trunc_cnt;

    axis_tx_pkt_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tready(m_tready), .mac_af(mac_af),
        .m_tid(m_tid), .busy(busy), .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic [2:0]  tid;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   last_hs_cyc = 0;
    logic ready_toggle = 1'b0;

    int   src_left[NS], src_len[NS], src_beat[NS], src_seq[NS];
    logic src_user[NS], src_hs[NS];

    function automatic logic [31:0] tag(input int s, input int q, input int b);
        return 32'((s << 24) | (q << 16) | (b + 1));
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i]          = (src_left[i] > 0);
            s_tdata[i*DW +: DW]  = DW'(tag(i, src_seq[i], src_beat[i]));
            s_tkeep[i*KW +: KW]  = KW'(i + 1);
            s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
            s_tuser[i]           = src_user[i];
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            src_left[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_seq[i] = 0;
            src_user[i] = 1'b0;
        end
        drive_src();
    endtask

    task automatic start_src(input int s, input int n, input int len, input logic u);
        src_left[s] = n; src_len[s] = len; src_beat[s] = 0; src_user[s] = u;
        drive_src();
    endtask

    task automatic push_pkt(input int s, input int q, input int len, input int nb,
                            input logic u, input int g0, input int g1);
        exp_t e;
        for (int b = 0; b < nb && b < MB; b++) begin
            e.data = tag(s, q, b);
            e.last = (b == len - 1) || (b == MB - 1);
            e.user = u || ((b == MB - 1) && (len > MB));
            e.tid  = 3'(s);
            e.gap  = (b == 0) ? g0 : g1;
            exp_q.push_back(e);
        end
    endtask

    // One clock: scoreboard check and handshake capture at negedge, source update after posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NS; i++) src_hs[i] = s_tvalid[i] && s_tready[i];
        if (!rst && m_tvalid && m_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_beat got data=%h tid=%0d", m_tdata[31:0], m_tid);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata[31:0] !== e.data || m_tdata[DW-1:32] !== '0 ||
                    m_tkeep !== KW'(e.tid) + KW'(1) || m_tlast !== e.last ||
                    m_tuser !== e.user || m_tid !== e.tid ||
                    (e.gap != 0 && (cyc - last_hs_cyc) != e.gap)) begin
                    bad++;
                    $display("FAIL sb_beat got data=%h last=%b user=%b tid=%0d gap=%0d want data=%h last=%b user=%b tid=%0d gap=%0d",
                             m_tdata[31:0], m_tlast, m_tuser, m_tid, cyc - last_hs_cyc,
                             e.data, e.last, e.user, e.tid, e.gap);
                end
            end
            last_hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (src_hs[i]) begin
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) begin
                    src_beat[i] = 0; src_seq[i]++; src_left[i]--;
                end
            end
        end
        if (ready_toggle) m_tready = ~m_tready;
        drive_src();
    endtask

    function automatic bit any_left();
        for (int i = 0; i < NS; i++) if (src_left[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input int budget, input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || any_left() || busy) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || any_left() || busy) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d busy=%b want pending=0 busy=0", nm, exp_q.size(), busy);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_tready = 1'b1; mac_af = 1'b0; ready_toggle = 1'b0;
        clear_src();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
        total++; if (s_tready !== '0) begin bad++; $display("FAIL reset_sready got=%b want=0", s_tready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (m_tid !== 3'd0) begin bad++; $display("FAIL reset_tid got=%0d want=0", m_tid); end
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_pkt_cnt got=%0d want=0", pkt_cnt); end
        total++; if (trunc_cnt !== 16'd0) begin bad++; $display("FAIL reset_trunc_cnt got=%0d want=0", trunc_cnt); end
    endtask

    task automatic test_single();
        apply_reset();
        last_hs_cyc = cyc;
        push_pkt(0, 0, 4, 4, 1'b0, 1, 1);
        start_src(0, 1, 4, 1'b0);
        wait_drain(50, "single");
        total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL single_pkt_cnt got=%0d want=1", pkt_cnt); end
        total++; if (m_tid !== 3'd0) begin bad++; $display("FAIL single_tid got=%0d want=0", m_tid); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        last_hs_cyc = cyc;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++)
                push_pkt(s, r, 2, 2, s == 2, (r == 0 && s == 0) ? 1 : 2, 1);
        for (int s = 0; s < NS; s++) start_src(s, 2, 2, s == 2);
        wait_drain(200, "rr");
        total++; if (pkt_cnt !== 32'd8) begin bad++; $display("FAIL rr_pkt_cnt got=%0d want=8", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        int start_c, done_c;
        apply_reset();
        last_hs_cyc = cyc;
        start_c = cyc;
        done_c = 0;
        push_pkt(1, 0, 4, 4, 1'b0, 2, 2);
        start_src(1, 1, 4, 1'b0);
        ready_toggle = 1'b1;
        for (int n = 0; n < 40 && pkt_cnt == 0; n++) begin
            cycle();
            #1;
            if (busy) begin
                total++;
                if (s_tready !== (4'(m_tready) << 1)) begin
                    bad++; $display("FAIL bp_mirror got=%b want=%b", s_tready, 4'(m_tready) << 1);
                end
            end
            if (pkt_cnt == 32'd1 && done_c == 0) done_c = cyc;
        end
        ready_toggle = 1'b0;
        m_tready = 1'b1;
        total++;
        if (done_c - start_c - 1 != 8) begin
            bad++; $display("FAIL bp_duration got=%0d want=8", done_c - start_c - 1);
        end
        wait_drain(50, "bp");
    endtask

    task automatic test_mac_af();
        apply_reset();
        mac_af = 1'b1;
        start_src(1, 1, 3, 1'b0);
        start_src(2, 1, 3, 1'b0);
        repeat (5) begin
            cycle();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL af_hold_busy got=%b want=0", busy); end
            total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL af_hold_tvalid got=%b want=0", m_tvalid); end
        end
        mac_af = 1'b0;
        last_hs_cyc = cyc;
        push_pkt(1, 0, 3, 3, 1'b0, 1, 1);
        cycle();
        total++;
        if (m_tid !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL af_release_grant got tid=%0d busy=%b want tid=1 busy=1", m_tid, busy);
        end
        cycle();
        mac_af = 1'b1;
        repeat (5) cycle();
        total++;
        if (busy !== 1'b0 || pkt_cnt !== 32'd1) begin
            bad++; $display("FAIL af_midpkt got busy=%b pkt_cnt=%0d want busy=0 pkt_cnt=1", busy, pkt_cnt);
        end
        mac_af = 1'b0;
        last_hs_cyc = cyc;
        push_pkt(2, 0, 3, 3, 1'b0, 1, 1);
        wait_drain(50, "af");
        total++; if (pkt_cnt !== 32'd2) begin bad++; $display("FAIL af_pkt_cnt got=%0d want=2", pkt_cnt); end
    endtask

    task automatic test_truncation();
        int n;
        apply_reset();
        last_hs_cyc = cyc;
        push_pkt(3, 0, 70, 70, 1'b0, 1, 1);
        start_src(3, 1, 70, 1'b0);
        cycle();
        cycle();
        push_pkt(0, 0, 1, 1, 1'b0, 8, 1);
        push_pkt(2, 0, 1, 1, 1'b0, 2, 1);
        start_src(0, 1, 1, 1'b0);
        start_src(2, 1, 1, 1'b0);
        for (n = 0; n < 200 && src_left[3] != 0; n++) begin
            cycle();
            #1;
            if (src_left[3] != 0 && src_beat[3] >= MB) begin
                total++;
                if (m_tvalid !== 1'b0) begin bad++; $display("FAIL trunc_drop_tvalid got=%b want=0", m_tvalid); end
            end
        end
        total++;
        if (src_left[3] != 0 || pkt_cnt !== 32'd1 || trunc_cnt !== 16'd1) begin
            bad++; $display("FAIL trunc_counts got left=%0d pkt_cnt=%0d trunc_cnt=%0d want left=0 pkt_cnt=1 trunc_cnt=1",
                            src_left[3], pkt_cnt, trunc_cnt);
        end
        wait_drain(50, "trunc");
        total++;
        if (pkt_cnt !== 32'd3 || trunc_cnt !== 16'd1) begin
            bad++; $display("FAIL trunc_final got pkt_cnt=%0d trunc_cnt=%0d want pkt_cnt=3 trunc_cnt=1", pkt_cnt, trunc_cnt);
        end
    endtask

    task automatic test_exact_max();
        apply_reset();
        last_hs_cyc = cyc;
        push_pkt(1, 0, MB, MB, 1'b0, 1, 1);
        start_src(1, 1, MB, 1'b0);
        wait_drain(150, "exact");
        total++;
        if (pkt_cnt !== 32'd1 || trunc_cnt !== 16'd0) begin
            bad++; $display("FAIL exact_max got pkt_cnt=%0d trunc_cnt=%0d want pkt_cnt=1 trunc_cnt=0", pkt_cnt, trunc_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        last_hs_cyc = cyc;
        push_pkt(1, 0, 1, 1, 1'b0, 1, 1);
        start_src(1, 1, 1, 1'b0);
        wait_drain(20, "rstmid_pre");
        last_hs_cyc = cyc;
        push_pkt(0, 0, 5, 2, 1'b0, 1, 1);
        start_src(0, 1, 5, 1'b0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", m_tvalid); end
        total++; if (s_tready !== '0) begin bad++; $display("FAIL rstmid_sready got=%b want=0", s_tready); end
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL rstmid_pkt_cnt got=%0d want=0", pkt_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_beats got pending=%0d want=0", exp_q.size()); end
        rst = 1'b0;
        clear_src();
        exp_q.delete();
        last_hs_cyc = cyc;
        push_pkt(0, 0, 1, 1, 1'b0, 1, 1);
        push_pkt(2, 0, 1, 1, 1'b0, 2, 1);
        start_src(0, 1, 1, 1'b0);
        start_src(2, 1, 1, 1'b0);
        wait_drain(30, "rstmid");
        total++; if (pkt_cnt !== 32'd2) begin bad++; $display("FAIL rstmid_after got pkt_cnt=%0d want=2", pkt_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        mac_af = 1'b0;
        clear_src();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mac_af();
        test_truncation();
        test_exact_max();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
